// File: rtl/fft_pkg.sv
// Shared defaults and arithmetic helpers for the radix-2 butterfly pipeline.
// Components are handled in a 64-bit signed container, so DW and TWW are limited to 32.
package fft_pkg;

    localparam int DW_DEF      = 16;
    localparam int TWW_DEF     = 16;
    localparam int TW_FRAC_DEF = 14;
    localparam int MAXW        = 64;

    typedef logic signed [MAXW-1:0] wide_t;

    function automatic wide_t cplx_re(input logic [MAXW-1:0] d, input int w);
        wide_t t;
        t = signed'(d << (MAXW - w));
        return t >>> (MAXW - w);
    endfunction

    function automatic wide_t cplx_im(input logic [MAXW-1:0] d, input int w);
        return cplx_re(d >> w, w);
    endfunction

    function automatic logic [MAXW-1:0] cplx_pack(input wide_t re, input wide_t im, input int w);
        logic [MAXW-1:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return ((im & mask) << w) | (re & mask);
    endfunction

    function automatic wide_t rnd_const(input int frac);
        return signed'(64'd1 << (frac - 1));
    endfunction

    function automatic logic out_of_range(input wide_t y, input int w);
        wide_t hi;
        wide_t lo;
        hi = signed'((64'd1 << (w - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        return (y > hi) || (y < lo);
    endfunction

    function automatic wide_t sat_dw(input wide_t y, input int w, input logic sat_en);
        wide_t hi;
        wide_t lo;
        wide_t res;
        hi = signed'((64'd1 << (w - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (sat_en) begin
            if (y > hi) begin
                res = hi;
            end else if (y < lo) begin
                res = lo;
            end else begin
                res = y;
            end
        end else begin
            res = cplx_re(y, w);
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_bf_pipe_if.sv
// Operand and result stream of the butterfly core, both with valid/ready flow control.
interface fft_bf_pipe_if
    import fft_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int TWW = TWW_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             sel_mem;
    logic [2*DW-1:0]  a0_data;
    logic [2*DW-1:0]  a1_data;
    logic [2*DW-1:0]  b0_data;
    logic [2*DW-1:0]  b1_data;
    logic [2*TWW-1:0] tw_data;
    logic             inv;
    logic             scale;
    logic             out_valid;
    logic             out_ready;
    logic [2*DW-1:0]  out0;
    logic [2*DW-1:0]  out1;

    modport master (
        output in_valid, sel_mem, a0_data, a1_data, b0_data, b1_data, tw_data, inv, scale, out_ready,
        input  in_ready, out_valid, out0, out1
    );

    modport slave (
        input  in_valid, sel_mem, a0_data, a1_data, b0_data, b1_data, tw_data, inv, scale, out_ready,
        output in_ready, out_valid, out0, out1
    );
endinterface

// File: rtl/fft_cmult.sv
// Two-stage complex multiplier x*w (optionally conjugated w) with half-up rounding to DW+1 bits.
module fft_cmult
    import fft_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TWW     = TWW_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2*DW-1:0]    x_data,
    input  logic [2*TWW-1:0]   tw_data,
    input  logic               inv,
    output logic signed [DW:0] p_re,
    output logic signed [DW:0] p_im
);
    localparam int PW = DW + TWW + 1;
    localparam int SW = PW + 1;

    logic signed [DW-1:0]  xre_s, xim_s, xre_r, xim_r;
    logic signed [TWW:0]   wre_s, wim_s, wre_r, wim_r;
    logic signed [PW-1:0]  rr_r, ii_r, ri_r, ir_r;
    logic signed [SW-1:0]  re_sum_s, im_sum_s;

    // operand unpack; conjugation runs one bit wider so negating -1.0 stays exact
    always_comb begin
        xre_s = DW'(cplx_re(64'(x_data), DW));
        xim_s = DW'(cplx_im(64'(x_data), DW));
        wre_s = (TWW+1)'(cplx_re(64'(tw_data), TWW));
        if (inv) begin
            wim_s = -((TWW+1)'(cplx_im(64'(tw_data), TWW)));
        end else begin
            wim_s = (TWW+1)'(cplx_im(64'(tw_data), TWW));
        end
    end

    // S1 operand register and S2 full-precision product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xre_r <= '0;
            xim_r <= '0;
            wre_r <= '0;
            wim_r <= '0;
            rr_r  <= '0;
            ii_r  <= '0;
            ri_r  <= '0;
            ir_r  <= '0;
        end else if (en) begin
            xre_r <= xre_s;
            xim_r <= xim_s;
            wre_r <= wre_s;
            wim_r <= wim_s;
            rr_r  <= PW'(xre_r) * PW'(wre_r);
            ii_r  <= PW'(xim_r) * PW'(wim_r);
            ri_r  <= PW'(xre_r) * PW'(wim_r);
            ir_r  <= PW'(xim_r) * PW'(wre_r);
        end
    end

    // combine partial products, round half-up, drop the twiddle fraction
    always_comb begin
        re_sum_s = SW'(rr_r) - SW'(ii_r) + SW'(rnd_const(TW_FRAC));
        im_sum_s = SW'(ri_r) + SW'(ir_r) + SW'(rnd_const(TW_FRAC));
        p_re     = (DW+1)'(re_sum_s >>> TW_FRAC);
        p_im     = (DW+1)'(im_sum_s >>> TW_FRAC);
    end

endmodule

// File: rtl/fft_bf_pipe.sv
// Pipelined radix-2 DIT butterfly, latency 3, valid/ready flow control, sticky overflow.
// Build option FFT_BF_SAT_EN: saturate out-of-range outputs instead of wrapping.
module fft_bf_pipe
    import fft_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TWW     = TWW_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fft_bf_pipe_if.slave  bus,
    input  logic          ovf_clr,
    output logic          ovf
);
`ifdef FFT_BF_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic                   advance_s;
    logic [2*DW-1:0]        x0_sel_s, x1_sel_s;
    logic                   v1_r, v2_r, scale_s1_r, scale_s2_r;
    logic [2*DW-1:0]        x0_s1_r, x0_s2_r;
    logic signed [DW:0]     p_re_s, p_im_s;
    logic signed [DW+1:0]   x0re_s, x0im_s;
    logic signed [DW+1:0]   y_s [4];
    logic signed [DW-1:0]   r_s [4];
    logic                   oor_s;
    logic                   out_valid_r, ovf_r;
    logic [2*DW-1:0]        out0_r, out1_r;

    assign advance_s     = !out_valid_r || bus.out_ready;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out0      = out0_r;
    assign bus.out1      = out1_r;
    assign ovf           = ovf_r;

    // memory bank select for the operand pair
    always_comb begin
        if (bus.sel_mem) begin
            x0_sel_s = bus.b0_data;
            x1_sel_s = bus.b1_data;
        end else begin
            x0_sel_s = bus.a0_data;
            x1_sel_s = bus.a1_data;
        end
    end

    fft_cmult #(
        .DW      (DW),
        .TWW     (TWW),
        .TW_FRAC (TW_FRAC)
    ) u_cmult (
        .clk     (clk),
        .rst     (rst),
        .en      (advance_s),
        .x_data  (x1_sel_s),
        .tw_data (bus.tw_data),
        .inv     (bus.inv),
        .p_re    (p_re_s),
        .p_im    (p_im_s)
    );

    // butterfly sums, optional floor halving, range check and reduction to DW bits
    always_comb begin
        x0re_s = (DW+2)'(cplx_re(64'(x0_s2_r), DW));
        x0im_s = (DW+2)'(cplx_im(64'(x0_s2_r), DW));
        y_s[0] = x0re_s + (DW+2)'(p_re_s);
        y_s[1] = x0im_s + (DW+2)'(p_im_s);
        y_s[2] = x0re_s - (DW+2)'(p_re_s);
        y_s[3] = x0im_s - (DW+2)'(p_im_s);
        oor_s  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (scale_s2_r) begin
                y_s[k] = y_s[k] >>> 1;
            end else begin
                y_s[k] = y_s[k];
            end
            oor_s  = oor_s | out_of_range(64'(y_s[k]), DW);
            r_s[k] = DW'(sat_dw(64'(y_s[k]), DW, SAT_EN));
        end
    end

    // pipeline side-band and output stage; everything holds while the output stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            scale_s1_r  <= 1'b0;
            scale_s2_r  <= 1'b0;
            x0_s1_r     <= '0;
            x0_s2_r     <= '0;
            out_valid_r <= 1'b0;
            out0_r      <= '0;
            out1_r      <= '0;
        end else if (advance_s) begin
            v1_r        <= bus.in_valid;
            scale_s1_r  <= bus.scale;
            x0_s1_r     <= x0_sel_s;
            v2_r        <= v1_r;
            scale_s2_r  <= scale_s1_r;
            x0_s2_r     <= x0_s1_r;
            out_valid_r <= v2_r;
            if (v2_r) begin
                out0_r <= (2*DW)'(cplx_pack(64'(r_s[0]), 64'(r_s[1]), DW));
                out1_r <= (2*DW)'(cplx_pack(64'(r_s[2]), 64'(r_s[3]), DW));
            end
        end
    end

    // sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (advance_s && v2_r && oor_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bf_pipe.sv
// Directed bench for fft_bf_pipe (DW=TWW=16, Q2.14 twiddles): vector table plus stream sequences.
module tb_fft_bf_pipe;
    localparam int DW  = 16;
    localparam int TWW = 16;
`ifdef FFT_BF_SAT_EN
    localparam int E_HI = 32767;
    localparam int E_LO = -32768;
`else
    localparam int E_HI = -2;
    localparam int E_LO = 1;
`endif

    typedef struct {
        logic        sel;
        logic [31:0] a0, a1, b0, b1, tw;
        logic        inv, scale;
        logic [31:0] e0, e1;
        logic        eovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ovf_clr;
    logic ovf;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl [11];
    vec_t sq [$];

    always #5 clk = ~clk;

    fft_bf_pipe_if #(.DW(DW), .TWW(TWW)) bus ();

    fft_bf_pipe #(.DW(DW), .TWW(TWW), .TW_FRAC(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .ovf_clr (ovf_clr),
        .ovf     (ovf)
    );

    function automatic logic [31:0] pk(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = 16'(re);
        i = 16'(im);
        return {i, r};
    endfunction

    function automatic vec_t mk(input logic sel, input logic [31:0] a0, a1, b0, b1, tw,
                                input logic inv, scale, input logic [31:0] e0, e1, input logic eovf);
        vec_t v;
        v.sel = sel; v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.tw = tw;
        v.inv = inv; v.scale = scale; v.e0 = e0; v.e1 = e1; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.sel_mem  = v.sel;
        bus.a0_data  = v.a0;
        bus.a1_data  = v.a1;
        bus.b0_data  = v.b0;
        bus.b1_data  = v.b1;
        bus.tw_data  = v.tw;
        bus.inv      = v.inv;
        bus.scale    = v.scale;
        bus.in_valid = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int lat;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".latency"}, 32'(lat), 32'd3);
        chk({nm, ".out0"}, bus.out0, v.e0);
        chk({nm, ".out1"}, bus.out1, v.e1);
        chk({nm, ".ovf"}, {31'd0, ovf}, {31'd0, v.eovf});
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic run_stream(input int stall_lo, input int stall_hi, input string nm);
        int c = 0;
        int sent = 0;
        int got = 0;
        int extra = 0;
        int n = sq.size();
        while (got < n && c < 200) begin
            @(negedge clk);
            c++;
            bus.out_ready = !(c >= stall_lo && c <= stall_hi);
            #1;
            if (bus.out_valid) begin
                if (!bus.out_ready) begin
                    chk($sformatf("%s.in_ready_stall%0d", nm, c), {31'd0, bus.in_ready}, 32'd0);
                end else begin
                    chk($sformatf("%s.r%0d.out0", nm, got), bus.out0, sq[got].e0);
                    chk($sformatf("%s.r%0d.out1", nm, got), bus.out1, sq[got].e1);
                    got++;
                end
            end
            if (sent < n) begin
                drive(sq[sent]);
                if (bus.in_ready) sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        chk({nm, ".count"}, 32'(got), 32'(n));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        chk({nm, ".no_extra"}, 32'(extra), 32'd0);
        sq.delete();
    endtask

    initial begin
        vec_t v;
        int stale;
        rst = 1'b1; ovf_clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.sel_mem = 1'b0; bus.inv = 1'b0; bus.scale = 1'b0;
        bus.a0_data = 32'd0; bus.a1_data = 32'd0; bus.b0_data = 32'd0; bus.b1_data = 32'd0;
        bus.tw_data = 32'd0;

        tbl[0]  = mk(1'b0, pk(100, 0), pk(50, 0), pk(-7777, 1234), pk(7, 7), pk(16384, 0), 1'b0, 1'b0, pk(150, 0), pk(50, 0), 1'b0);
        tbl[1]  = mk(1'b0, pk(100, 0), pk(0, 50), pk(-7777, 1234), pk(7, 7), pk(0, -16384), 1'b0, 1'b0, pk(150, 0), pk(50, 0), 1'b0);
        tbl[2]  = mk(1'b0, pk(100, 0), pk(0, 50), pk(-7777, 1234), pk(7, 7), pk(0, -16384), 1'b1, 1'b0, pk(50, 0), pk(150, 0), 1'b0);
        tbl[3]  = mk(1'b0, pk(32767, 0), pk(32767, 0), pk(1, 1), pk(1, 1), pk(16384, 0), 1'b0, 1'b0, pk(E_HI, 0), pk(0, 0), 1'b1);
        tbl[4]  = mk(1'b0, pk(32767, 0), pk(32767, 0), pk(1, 1), pk(1, 1), pk(16384, 0), 1'b0, 1'b1, pk(32767, 0), pk(0, 0), 1'b0);
        tbl[5]  = mk(1'b1, pk(999, 999), pk(-999, 5), pk(-200, 30), pk(10, -20), pk(0, 16384), 1'b0, 1'b0, pk(-180, 40), pk(-220, 20), 1'b0);
        tbl[6]  = mk(1'b0, pk(0, 0), pk(3, 0), pk(55, 55), pk(66, 66), pk(8192, 0), 1'b0, 1'b0, pk(2, 0), pk(-2, 0), 1'b0);
        tbl[7]  = mk(1'b0, pk(0, 0), pk(-3, 0), pk(55, 55), pk(66, 66), pk(8192, 0), 1'b0, 1'b0, pk(-1, 0), pk(1, 0), 1'b0);
        tbl[8]  = mk(1'b0, pk(-3, 1), pk(0, 0), pk(55, 55), pk(66, 66), pk(16384, 0), 1'b0, 1'b1, pk(-2, 0), pk(-2, 0), 1'b0);
        tbl[9]  = mk(1'b0, pk(-32768, 0), pk(32767, 0), pk(0, 0), pk(0, 0), pk(16384, 0), 1'b0, 1'b0, pk(-1, 0), pk(E_LO, 0), 1'b1);
        tbl[10] = mk(1'b0, pk(1000, -500), pk(300, 400), pk(0, 0), pk(0, 0), pk(11585, -11585), 1'b0, 1'b0, pk(1495, -429), pk(505, -571), 1'b0);

        #12;
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.out0", bus.out0, 32'd0);
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_vec(tbl[i], $sformatf("v%0d", i));
        end

        // 8 back-to-back sets, output stalled in cycles 4..8
        for (int i = 0; i < 8; i++) begin
            sq.push_back(mk(1'b0, pk(i * 10 + 1, i), pk(i, -i), pk(0, 0), pk(0, 0), pk(16384, 0), 1'b0, 1'b0,
                            pk(i * 11 + 1, 0), pk(i * 9 + 1, 2 * i), 1'b0));
        end
        run_stream(4, 8, "bp");

        // alternating memory select with distinct A/B data
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                sq.push_back(mk(1'b0, pk(10 + i, 1), pk(5, 0), pk(-20 - i, 2), pk(0, 7), pk(16384, 0), 1'b0, 1'b0,
                                pk(15 + i, 1), pk(5 + i, 1), 1'b0));
            end else begin
                sq.push_back(mk(1'b1, pk(10 + i, 1), pk(5, 0), pk(-20 - i, 2), pk(0, 7), pk(16384, 0), 1'b0, 1'b0,
                                pk(-20 - i, 9), pk(-20 - i, -5), 1'b0));
            end
        end
        run_stream(0, -1, "sel");

        // overflow and ovf_clr on the same load edge: set wins, then stays sticky
        @(negedge clk);
        drive(tbl[9]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr.out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("clr.set_wins", {31'd0, ovf}, 32'd1);
        v = tbl[0];
        v.eovf = 1'b1;
        apply_vec(v, "sticky");
        chk("clr.cleared", {31'd0, ovf}, 32'd0);

        // reset with three sets in flight
        @(negedge clk);
        drive(tbl[3]);
        @(negedge clk);
        drive(tbl[0]);
        @(negedge clk);
        drive(tbl[1]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst2.pre_ovf", {31'd0, ovf}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst2.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst2.out0", bus.out0, 32'd0);
        chk("rst2.out1", bus.out1, 32'd0);
        chk("rst2.ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("rst2.no_stale", 32'(stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
